// File: rtl/conv_tile_ctrl.sv
// conv_tile_ctrl: address/strobe sequencer for the convolution PE array.
// Kernels load once per job; each tile then loads features, runs channels, drains and streams results.
module conv_tile_ctrl #(
  parameter int ROWS   = 64,
  parameter int KROWS  = 4,
  parameter int CO_MAX = 4,
  parameter int CI_MAX = 256,
  parameter int PE_LAT = 3,
  parameter int ACC_W  = 25,
  localparam int NOUT_MAX = (ROWS - KROWS + 1) * CO_MAX,
  localparam int WAW = $clog2(KROWS * CO_MAX),
  localparam int IAW = $clog2(ROWS),
  localparam int RSW = $clog2(NOUT_MAX)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_conv,
  input  logic [8:0]       cfg_ci,
  input  logic [1:0]       cfg_co,
  input  logic [7:0]       cfg_tiles,
  output logic             busy,
  output logic             err_cfg,
  output logic             read_W,
  input  logic             w_valid,
  output logic             w_we,
  output logic [WAW-1:0]   w_addr,
  output logic             read_I,
  input  logic             i_valid,
  output logic             i_we,
  output logic [IAW-1:0]   i_addr,
  output logic             pe_en,
  output logic             pe_first,
  output logic             pe_last,
  output logic [RSW-1:0]   res_sel,
  input  logic [ACC_W-1:0] res_data,
  output logic             write_o,
  input  logic             o_ready,
  output logic [ACC_W-1:0] Odata,
  output logic             end_conv
);

  localparam int CIW = (CI_MAX > 1) ? $clog2(CI_MAX) : 1;
  localparam int DW  = (PE_LAT > 1) ? $clog2(PE_LAT) : 1;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOAD_W  = 3'd1;
  localparam logic [2:0] S_LOAD_I  = 3'd2;
  localparam logic [2:0] S_COMPUTE = 3'd3;
  localparam logic [2:0] S_DRAIN   = 3'd4;
  localparam logic [2:0] S_WRITE   = 3'd5;
  localparam logic [2:0] S_DONE    = 3'd6;

  logic [2:0]     state_q, state_d;
  logic [WAW-1:0] wCnt_q, wCnt_d;
  logic [IAW-1:0] iCnt_q, iCnt_d;
  logic [CIW-1:0] ciCnt_q, ciCnt_d;
  logic [DW-1:0]  drCnt_q, drCnt_d;
  logic [RSW-1:0] oCnt_q, oCnt_d;
  logic [7:0]     tile_q, tile_d;
  logic [8:0]     cfgCi_q, cfgCi_d;
  logic [1:0]     cfgCo_q, cfgCo_d;
  logic [7:0]     cfgTiles_q, cfgTiles_d;
  logic           errCfg_q, errCfg_d;

  logic           cfgOk, ciLast;
  logic [WAW-1:0] wLast;
  logic [RSW-1:0] oLast;

  // Last-index values derive from the latched kernel count so mid-job cfg changes are harmless.
  assign cfgOk  = (cfg_ci != 9'd0) && (32'(cfg_ci) <= CI_MAX) && (cfg_tiles != 8'd0);
  assign wLast  = WAW'((32'(cfgCo_q) + 1) * KROWS - 1);
  assign oLast  = RSW'((32'(cfgCo_q) + 1) * (ROWS - KROWS + 1) - 1);
  assign ciLast = (9'(ciCnt_q) == (cfgCi_q - 9'd1));

  assign busy     = (state_q != S_IDLE);
  assign err_cfg  = errCfg_q;
  assign read_W   = (state_q == S_LOAD_W);
  assign w_we     = read_W & w_valid;
  assign w_addr   = wCnt_q;
  assign read_I   = (state_q == S_LOAD_I);
  assign i_we     = read_I & i_valid;
  assign i_addr   = iCnt_q;
  assign pe_en    = (state_q == S_COMPUTE);
  assign pe_first = pe_en && (ciCnt_q == '0);
  assign pe_last  = pe_en && ciLast;
  assign write_o  = (state_q == S_WRITE);
  assign res_sel  = oCnt_q;
  assign Odata    = res_data;
  assign end_conv = (state_q == S_DONE);

  // Each counter returns to zero on the transition that leaves its state.
  always_comb begin
    state_d    = state_q;
    wCnt_d     = wCnt_q;
    iCnt_d     = iCnt_q;
    ciCnt_d    = ciCnt_q;
    drCnt_d    = drCnt_q;
    oCnt_d     = oCnt_q;
    tile_d     = tile_q;
    cfgCi_d    = cfgCi_q;
    cfgCo_d    = cfgCo_q;
    cfgTiles_d = cfgTiles_q;
    errCfg_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_conv) begin
          if (cfgOk) begin
            state_d    = S_LOAD_W;
            cfgCi_d    = cfg_ci;
            cfgCo_d    = cfg_co;
            cfgTiles_d = cfg_tiles;
            tile_d     = '0;
          end else begin
            errCfg_d = 1'b1;
          end
        end
      end
      S_LOAD_W: begin
        if (w_we) begin
          if (wCnt_q == wLast) begin
            wCnt_d  = '0;
            state_d = S_LOAD_I;
          end else begin
            wCnt_d = wCnt_q + 1'b1;
          end
        end
      end
      S_LOAD_I: begin
        if (i_we) begin
          if (iCnt_q == IAW'(ROWS - 1)) begin
            iCnt_d  = '0;
            state_d = S_COMPUTE;
          end else begin
            iCnt_d = iCnt_q + 1'b1;
          end
        end
      end
      S_COMPUTE: begin
        if (ciLast) begin
          ciCnt_d = '0;
          state_d = S_DRAIN;
        end else begin
          ciCnt_d = ciCnt_q + 1'b1;
        end
      end
      S_DRAIN: begin
        if (drCnt_q == DW'(PE_LAT - 1)) begin
          drCnt_d = '0;
          state_d = S_WRITE;
        end else begin
          drCnt_d = drCnt_q + 1'b1;
        end
      end
      S_WRITE: begin
        if (o_ready) begin
          if (oCnt_q == oLast) begin
            oCnt_d = '0;
            if (tile_q == (cfgTiles_q - 8'd1)) begin
              tile_d  = '0;
              state_d = S_DONE;
            end else begin
              tile_d  = tile_q + 8'd1;
              state_d = S_LOAD_I;
            end
          end else begin
            oCnt_d = oCnt_q + 1'b1;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      wCnt_q     <= '0;
      iCnt_q     <= '0;
      ciCnt_q    <= '0;
      drCnt_q    <= '0;
      oCnt_q     <= '0;
      tile_q     <= '0;
      cfgCi_q    <= '0;
      cfgCo_q    <= '0;
      cfgTiles_q <= '0;
      errCfg_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      wCnt_q     <= wCnt_d;
      iCnt_q     <= iCnt_d;
      ciCnt_q    <= ciCnt_d;
      drCnt_q    <= drCnt_d;
      oCnt_q     <= oCnt_d;
      tile_q     <= tile_d;
      cfgCi_q    <= cfgCi_d;
      cfgCo_q    <= cfgCo_d;
      cfgTiles_q <= cfgTiles_d;
      errCfg_q   <= errCfg_d;
    end
  end

endmodule

// File: tb/tb_conv_tile_ctrl.sv
// tb_conv_tile_ctrl: randomized self-checking bench for conv_tile_ctrl.
// A negedge recorder captures every job; expectations come from job-level arithmetic over the trace.
module tb_conv_tile_ctrl;

  localparam int ROWS   = 64;
  localparam int KROWS  = 4;
  localparam int PE_LAT = 3;

  logic        clk, rst, start_conv;
  logic [8:0]  cfg_ci;
  logic [1:0]  cfg_co;
  logic [7:0]  cfg_tiles;
  logic        busy, err_cfg, read_W, w_valid, w_we, read_I, i_valid, i_we;
  logic [3:0]  w_addr;
  logic [5:0]  i_addr;
  logic        pe_en, pe_first, pe_last, write_o, o_ready, end_conv;
  logic [7:0]  res_sel;
  logic [24:0] res_data, Odata;

  int nChecks = 0;
  int nFails  = 0;
  bit recOn   = 0;

  typedef struct {
    logic rw, wv, wwe, ri, iv, iwe, pe, pf, pl, wo, ordy, ec, ecfg, busy;
    logic [3:0]  wa;
    logic [5:0]  ia;
    logic [7:0]  rs;
    logic [24:0] od, rd;
  } rec_t;

  typedef struct {
    int nWwe, nIwe, nPe, nPf, nPl, nRuns, nAcc, nEnd, nErr;
    int addrErr, weErr, odErr, runErr, stall10, wAfterI;
  } stat_t;

  rec_t trace[$];

  conv_tile_ctrl dut (
    .clk(clk), .rst(rst), .start_conv(start_conv), .cfg_ci(cfg_ci), .cfg_co(cfg_co),
    .cfg_tiles(cfg_tiles), .busy(busy), .err_cfg(err_cfg), .read_W(read_W), .w_valid(w_valid),
    .w_we(w_we), .w_addr(w_addr), .read_I(read_I), .i_valid(i_valid), .i_we(i_we),
    .i_addr(i_addr), .pe_en(pe_en), .pe_first(pe_first), .pe_last(pe_last), .res_sel(res_sel),
    .res_data(res_data), .write_o(write_o), .o_ready(o_ready), .Odata(Odata), .end_conv(end_conv)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  always @(negedge clk) begin
    if (recOn) begin
      rec_t r;
      r.rw = read_W; r.wv = w_valid; r.wwe = w_we; r.wa = w_addr;
      r.ri = read_I; r.iv = i_valid; r.iwe = i_we; r.ia = i_addr;
      r.pe = pe_en; r.pf = pe_first; r.pl = pe_last;
      r.wo = write_o; r.ordy = o_ready; r.rs = res_sel; r.od = Odata; r.rd = res_data;
      r.ec = end_conv; r.ecfg = err_cfg; r.busy = busy;
      trace.push_back(r);
    end
  end

  function automatic logic pick(input int mode, input int c);
    if (mode == 0) return 1'b1;
    if (mode == 1) return ((c % 2) == 0);
    return ($urandom_range(99) < 60);
  endfunction

  // Walks the recorded job: addresses must step 0,1,2.. on accepted handshakes, holding otherwise.
  function automatic stat_t summarize(input int ci, input int co);
    stat_t s;
    int expW, expI, expO, nout, run;
    bit seenI;
    s = '{default: 0};
    expW = 0; expI = 0; expO = 0; run = 0; seenI = 0;
    nout = (ROWS - KROWS + 1) * (co + 1);
    foreach (trace[k]) begin
      if (trace[k].rw === 1'b1) begin
        if (seenI) s.wAfterI++;
        if (trace[k].wa !== expW) s.addrErr++;
        if (trace[k].wwe !== trace[k].wv) s.weErr++;
        if (trace[k].wv === 1'b1) begin s.nWwe++; expW++; end
      end else if (trace[k].wwe !== 1'b0) s.weErr++;
      if (trace[k].ri === 1'b1) begin
        seenI = 1;
        if (trace[k].ia !== expI) s.addrErr++;
        if (trace[k].iwe !== trace[k].iv) s.weErr++;
        if (trace[k].iv === 1'b1) begin s.nIwe++; expI = (expI + 1) % ROWS; end
      end else if (trace[k].iwe !== 1'b0) s.weErr++;
      if (trace[k].pe === 1'b1) begin
        s.nPe++;
        if (trace[k].pf !== (run == 0)) s.runErr++;
        if (trace[k].pl !== (run == ci - 1)) s.runErr++;
        if (trace[k].pf === 1'b1) s.nPf++;
        if (trace[k].pl === 1'b1) s.nPl++;
        run++;
      end else begin
        if (run != 0) begin s.nRuns++; if (run != ci) s.runErr++; end
        run = 0;
        if (trace[k].pf !== 1'b0 || trace[k].pl !== 1'b0) s.runErr++;
      end
      if (trace[k].wo === 1'b1) begin
        if (trace[k].rs !== expO) s.addrErr++;
        if (trace[k].rs === 8'd10 && trace[k].ordy === 1'b0) s.stall10++;
        if (trace[k].ordy === 1'b1) begin s.nAcc++; expO = (expO + 1) % nout; end
      end
      if (trace[k].od !== trace[k].rd) s.odErr++;
      if (trace[k].ec === 1'b1) s.nEnd++;
      if (trace[k].ecfg === 1'b1) s.nErr++;
    end
    return s;
  endfunction

  task automatic applyReset();
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Runs one job; cfg inputs are scrambled after the start cycle since the DUT must latch them.
  task automatic applyStimulus(input int ci, input int co, input int tiles, input int wMode,
                               input int iMode, input int oMode, input bit stall, input bit poke,
                               input int abortAt, output bit done, output bit aborted);
    int budget, stallCnt, nout;
    bit poked;
    nout = (ROWS - KROWS + 1) * (co + 1);
    budget = 4 * (KROWS * (co + 1) + tiles * (ROWS + ci + PE_LAT + nout)) + 50;
    done = 0; aborted = 0; stallCnt = 0; poked = 0;
    trace.delete();
    @(posedge clk); #1;
    start_conv = 1'b1; cfg_ci = 9'(ci); cfg_co = 2'(co); cfg_tiles = 8'(tiles);
    w_valid = pick(wMode, 0); i_valid = pick(iMode, 0); o_ready = pick(oMode, 0);
    res_data = 25'($urandom);
    recOn = 1;
    for (int c = 1; c <= budget && !done && !aborted; c++) begin
      @(posedge clk); #1;
      start_conv = 1'b0;
      cfg_ci = 9'($urandom); cfg_co = 2'($urandom); cfg_tiles = 8'($urandom);
      w_valid = pick(wMode, c); i_valid = pick(iMode, c); res_data = 25'($urandom);
      if (stall && write_o && res_sel == 8'd10 && stallCnt < 5) begin
        o_ready = 1'b0; stallCnt++;
      end else o_ready = pick(oMode, c);
      if (poke && pe_en && !poked) begin start_conv = 1'b1; poked = 1; end
      if (abortAt >= 0 && write_o && int'(res_sel) == abortAt) begin rst = 1'b1; aborted = 1; end
      @(negedge clk);
      if (end_conv === 1'b1) done = 1;
    end
    #1 recOn = 0;
  endtask

  task automatic test_reset();
    logic [28:0] got;
    w_valid = 1'b1; i_valid = 1'b1; o_ready = 1'b1; start_conv = 1'b1;
    cfg_ci = 9'd3; cfg_co = 2'd0; cfg_tiles = 8'd1; res_data = 25'($urandom);
    repeat (2) @(negedge clk);
    got = {busy, err_cfg, read_W, w_we, w_addr, read_I, i_we, i_addr, pe_en, pe_first, pe_last,
           res_sel, write_o, end_conv};
    nChecks++; if (got !== '0) begin nFails++; $display("[TB] FAIL reset outputs got %h want 0", got); end
    nChecks++; if (Odata !== res_data) begin nFails++; $display("[TB] FAIL reset Odata got %h want %h", Odata, res_data); end
    @(posedge clk); #1 start_conv = 1'b0; rst = 1'b0;
    @(negedge clk);
    nChecks++; if (busy !== 1'b0) begin nFails++; $display("[TB] FAIL reset idle busy got %b want 0", busy); end
  endtask

  task automatic test_basic();
    bit done, aborted;
    stat_t st;
    int tI0, tC0, tD0, tWr0, tDone;
    applyStimulus(3, 0, 1, 0, 0, 0, 0, 0, -1, done, aborted);
    nChecks++; if (done !== 1'b1) begin nFails++; $display("[TB] FAIL basic done got %b want 1", done); applyReset(); end
    tI0 = 1 + KROWS; tC0 = tI0 + ROWS; tD0 = tC0 + 3; tWr0 = tD0 + PE_LAT; tDone = tWr0 + (ROWS - KROWS + 1);
    nChecks++; if (trace.size() !== tDone + 1) begin nFails++; $display("[TB] FAIL basic length got %0d want %0d", trace.size(), tDone + 1); end
    for (int c = 0; c <= tDone && c < trace.size(); c++) begin
      logic [7:0] expV, gotV;
      expV = {c >= 1 && c < tI0, c >= tI0 && c < tC0, c >= tC0 && c < tD0, c == tC0, c == tD0 - 1,
              c >= tWr0 && c < tDone, c == tDone, c >= 1 && c <= tDone};
      gotV = {trace[c].rw, trace[c].ri, trace[c].pe, trace[c].pf, trace[c].pl, trace[c].wo,
              trace[c].ec, trace[c].busy};
      nChecks++; if (gotV !== expV) begin nFails++; $display("[TB] FAIL basic cycle %0d strobes got %b want %b", c, gotV, expV); end
      if (c >= tWr0 && c < tDone) begin
        nChecks++; if (trace[c].rs !== c - tWr0) begin nFails++; $display("[TB] FAIL basic cycle %0d res_sel got %0d want %0d", c, trace[c].rs, c - tWr0); end
      end
    end
    st = summarize(3, 0);
    nChecks++; if (st.addrErr !== 0) begin nFails++; $display("[TB] FAIL basic addr errors got %0d want 0", st.addrErr); end
    nChecks++; if (st.odErr !== 0) begin nFails++; $display("[TB] FAIL basic Odata errors got %0d want 0", st.odErr); end
  endtask

  task automatic test_cfg_errors();
    int badCi[4];
    int badTiles[4];
    badCi[0] = 0; badCi[1] = 300; badCi[2] = $urandom_range(511, 257); badCi[3] = $urandom_range(256, 1);
    badTiles[0] = 1; badTiles[1] = 2; badTiles[2] = $urandom_range(255, 1); badTiles[3] = 0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      start_conv = 1'b1; cfg_ci = 9'(badCi[k]); cfg_co = 2'($urandom); cfg_tiles = 8'(badTiles[k]);
      @(negedge clk);
      nChecks++; if ({err_cfg, busy} !== 2'b00) begin nFails++; $display("[TB] FAIL cfgerr %0d start cycle err/busy got %b want 00", k, {err_cfg, busy}); end
      @(posedge clk); #1 start_conv = 1'b0;
      @(negedge clk);
      nChecks++; if ({err_cfg, busy} !== 2'b10) begin nFails++; $display("[TB] FAIL cfgerr %0d pulse err/busy got %b want 10", k, {err_cfg, busy}); end
      @(negedge clk);
      nChecks++; if ({err_cfg, busy} !== 2'b00) begin nFails++; $display("[TB] FAIL cfgerr %0d after err/busy got %b want 00", k, {err_cfg, busy}); end
    end
  endtask

  task automatic test_backpressure();
    bit done, aborted;
    stat_t st;
    int ci, co, nout;
    ci = $urandom_range(8, 2); co = $urandom_range(3, 0); nout = (ROWS - KROWS + 1) * (co + 1);
    applyStimulus(ci, co, 1, 1, 2, 0, 1, 0, -1, done, aborted);
    st = summarize(ci, co);
    nChecks++; if (done !== 1'b1) begin nFails++; $display("[TB] FAIL bp done got %b want 1", done); applyReset(); end
    nChecks++; if (st.nWwe !== KROWS * (co + 1)) begin nFails++; $display("[TB] FAIL bp kernel writes got %0d want %0d", st.nWwe, KROWS * (co + 1)); end
    nChecks++; if (st.nIwe !== ROWS) begin nFails++; $display("[TB] FAIL bp feature writes got %0d want %0d", st.nIwe, ROWS); end
    nChecks++; if (st.nAcc !== nout) begin nFails++; $display("[TB] FAIL bp accepted writes got %0d want %0d", st.nAcc, nout); end
    nChecks++; if (st.stall10 !== 5) begin nFails++; $display("[TB] FAIL bp stall cycles at 10 got %0d want 5", st.stall10); end
    nChecks++; if (st.addrErr + st.weErr !== 0) begin nFails++; $display("[TB] FAIL bp addr/strobe errors got %0d want 0", st.addrErr + st.weErr); end
    nChecks++; if (st.odErr !== 0) begin nFails++; $display("[TB] FAIL bp Odata errors got %0d want 0", st.odErr); end
    nChecks++; if (st.nEnd !== 1) begin nFails++; $display("[TB] FAIL bp end pulses got %0d want 1", st.nEnd); end
  endtask

  task automatic test_multi_tile();
    bit done, aborted;
    stat_t st;
    int ci;
    ci = $urandom_range(6, 1);
    applyStimulus(ci, 3, 3, 2, 2, 2, 0, 0, -1, done, aborted);
    st = summarize(ci, 3);
    nChecks++; if (done !== 1'b1) begin nFails++; $display("[TB] FAIL multi done got %b want 1", done); applyReset(); end
    nChecks++; if (st.nWwe !== 16) begin nFails++; $display("[TB] FAIL multi kernel writes got %0d want 16", st.nWwe); end
    nChecks++; if (st.wAfterI !== 0) begin nFails++; $display("[TB] FAIL multi kernel reload cycles got %0d want 0", st.wAfterI); end
    nChecks++; if (st.nIwe !== 3 * ROWS) begin nFails++; $display("[TB] FAIL multi feature writes got %0d want %0d", st.nIwe, 3 * ROWS); end
    nChecks++; if (st.nAcc !== 3 * 244) begin nFails++; $display("[TB] FAIL multi accepted writes got %0d want %0d", st.nAcc, 3 * 244); end
    nChecks++; if (st.nPe !== 3 * ci) begin nFails++; $display("[TB] FAIL multi pe cycles got %0d want %0d", st.nPe, 3 * ci); end
    nChecks++; if (st.runErr + st.addrErr + st.weErr !== 0) begin nFails++; $display("[TB] FAIL multi sequence errors got %0d want 0", st.runErr + st.addrErr + st.weErr); end
    nChecks++; if (st.nEnd !== 1) begin nFails++; $display("[TB] FAIL multi end pulses got %0d want 1", st.nEnd); end
  endtask

  task automatic test_ignore_start();
    bit done, aborted;
    stat_t st;
    applyStimulus(6, 1, 1, 0, 0, 0, 0, 1, -1, done, aborted);
    st = summarize(6, 1);
    nChecks++; if (done !== 1'b1) begin nFails++; $display("[TB] FAIL ignore done got %b want 1", done); applyReset(); end
    nChecks++; if (st.nPe !== 6 || st.nRuns !== 1) begin nFails++; $display("[TB] FAIL ignore pe cycles/runs got %0d/%0d want 6/1", st.nPe, st.nRuns); end
    nChecks++; if (st.nAcc !== 122) begin nFails++; $display("[TB] FAIL ignore accepted writes got %0d want 122", st.nAcc); end
    nChecks++; if (st.nWwe !== 8 || st.nErr !== 0) begin nFails++; $display("[TB] FAIL ignore kernel writes/err got %0d/%0d want 8/0", st.nWwe, st.nErr); end
    nChecks++; if (st.nEnd !== 1) begin nFails++; $display("[TB] FAIL ignore end pulses got %0d want 1", st.nEnd); end
  endtask

  task automatic test_ci_one();
    bit done, aborted;
    stat_t st;
    int co, tiles;
    co = $urandom_range(3, 0); tiles = $urandom_range(2, 1);
    applyStimulus(1, co, tiles, 2, 2, 2, 0, 0, -1, done, aborted);
    st = summarize(1, co);
    nChecks++; if (done !== 1'b1) begin nFails++; $display("[TB] FAIL ci1 done got %b want 1", done); applyReset(); end
    nChecks++; if (st.nPe !== tiles || st.nRuns !== tiles) begin nFails++; $display("[TB] FAIL ci1 pe cycles/runs got %0d/%0d want %0d", st.nPe, st.nRuns, tiles); end
    nChecks++; if (st.nPf !== tiles || st.nPl !== tiles) begin nFails++; $display("[TB] FAIL ci1 first/last got %0d/%0d want %0d", st.nPf, st.nPl, tiles); end
    nChecks++; if (st.runErr !== 0) begin nFails++; $display("[TB] FAIL ci1 run errors got %0d want 0", st.runErr); end
  endtask

  task automatic test_reset_mid_write();
    bit done, aborted;
    stat_t st;
    logic [28:0] got;
    int ci, co, nout;
    ci = $urandom_range(10, 1); co = $urandom_range(3, 0); nout = (ROWS - KROWS + 1) * (co + 1);
    applyStimulus(ci, co, 2, 2, 2, 2, 0, 0, $urandom_range(nout - 1, 0), done, aborted);
    nChecks++; if (aborted !== 1'b1) begin nFails++; $display("[TB] FAIL rstmid reached write got %b want 1", aborted); rst = 1'b1; end
    got = {busy, err_cfg, read_W, w_we, w_addr, read_I, i_we, i_addr, pe_en, pe_first, pe_last,
           res_sel, write_o, end_conv};
    nChecks++; if (got !== '0) begin nFails++; $display("[TB] FAIL rstmid outputs got %h want 0", got); end
    nChecks++; if (Odata !== res_data) begin nFails++; $display("[TB] FAIL rstmid Odata got %h want %h", Odata, res_data); end
    st = summarize(ci, co);
    nChecks++; if (st.nEnd !== 0) begin nFails++; $display("[TB] FAIL rstmid end pulses got %0d want 0", st.nEnd); end
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    nChecks++; if (busy !== 1'b0) begin nFails++; $display("[TB] FAIL rstmid idle busy got %b want 0", busy); end
    applyStimulus(ci, co, 1, 0, 0, 0, 0, 0, -1, done, aborted);
    st = summarize(ci, co);
    nChecks++; if (done !== 1'b1) begin nFails++; $display("[TB] FAIL rstmid rerun done got %b want 1", done); applyReset(); end
    nChecks++; if (st.nAcc !== nout || st.nEnd !== 1) begin nFails++; $display("[TB] FAIL rstmid rerun writes/ends got %0d/%0d want %0d/1", st.nAcc, st.nEnd, nout); end
  endtask

  task automatic test_random();
    for (int j = 0; j < 3; j++) begin
      bit done, aborted;
      stat_t st;
      int ci, co, tiles, nout;
      ci = $urandom_range(40, 1); co = $urandom_range(3, 0); tiles = $urandom_range(2, 1);
      nout = (ROWS - KROWS + 1) * (co + 1);
      applyStimulus(ci, co, tiles, 2, 2, 2, 0, 0, -1, done, aborted);
      st = summarize(ci, co);
      nChecks++; if (done !== 1'b1) begin nFails++; $display("[TB] FAIL rand%0d done got %b want 1", j, done); applyReset(); end
      nChecks++; if (st.nWwe !== KROWS * (co + 1)) begin nFails++; $display("[TB] FAIL rand%0d kernel writes got %0d want %0d", j, st.nWwe, KROWS * (co + 1)); end
      nChecks++; if (st.nIwe !== tiles * ROWS) begin nFails++; $display("[TB] FAIL rand%0d feature writes got %0d want %0d", j, st.nIwe, tiles * ROWS); end
      nChecks++; if (st.nAcc !== tiles * nout) begin nFails++; $display("[TB] FAIL rand%0d accepted writes got %0d want %0d", j, st.nAcc, tiles * nout); end
      nChecks++; if (st.nPe !== tiles * ci) begin nFails++; $display("[TB] FAIL rand%0d pe cycles got %0d want %0d", j, st.nPe, tiles * ci); end
      nChecks++; if (st.addrErr + st.weErr + st.odErr + st.runErr !== 0) begin nFails++; $display("[TB] FAIL rand%0d sequence errors got %0d want 0", j, st.addrErr + st.weErr + st.odErr + st.runErr); end
      nChecks++; if (st.nEnd !== 1) begin nFails++; $display("[TB] FAIL rand%0d end pulses got %0d want 1", j, st.nEnd); end
    end
  endtask

  initial begin
    rst = 1'b1; start_conv = 1'b0; cfg_ci = '0; cfg_co = '0; cfg_tiles = '0;
    w_valid = 1'b0; i_valid = 1'b0; o_ready = 1'b0; res_data = '0;
    test_reset();
    test_basic();
    test_cfg_errors();
    test_backpressure();
    test_multi_tile();
    test_ignore_start();
    test_ci_one();
    test_reset_mid_write();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
